// File: rtl/montgomery_exit_red.sv
`default_nettype none
// ============================================================================
//  Module   : montgomery_exit_red
//  Function : Bit-serial Montgomery reduction (REDC). Converts an operand
//             out of the Montgomery domain: y = a * 2^(-m_size) mod m.
//             It uses the enable_p / done_irq_p pulse handshake so it can
//             chain directly with the other modular-arithmetic stages.
//  Revision : 1.0  initial release
// ============================================================================
module montgomery_exit_red #(
  parameter int NBITS = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  input  logic [11:0]      m_size,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p,
  output logic             err_p
);

  localparam logic [11:0] C_NBITS = 12'(NBITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_REDUCE = 3'd2,
    S_FINAL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  // One extra bit so that acc + m can never overflow.
  logic [NBITS:0]   acc_q, acc_d;
  logic [NBITS-1:0] m_reg_q, m_reg_d;
  logic [11:0]      cnt_q, cnt_d;
  logic [NBITS-1:0] y_q, y_d;

  logic [NBITS:0]   w_m_ext;
  logic [NBITS:0]   w_sum;
  logic [NBITS:0]   w_sub;
  logic             w_ge;
  logic             w_reject;

  assign w_m_ext  = {1'b0, m_reg_q};
  assign w_sum    = acc_q + w_m_ext;
  assign w_sub    = acc_q - w_m_ext;
  assign w_ge     = (acc_q >= w_m_ext);
  // An even modulus has no inverse of 2; the exponent must lie in 1..NBITS.
  assign w_reject = (m_reg_q[0] == 1'b0) || (cnt_q == 12'd0) || (cnt_q > C_NBITS);

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      m_reg_q <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_reg_q <= m_reg_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_reg_d = m_reg_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE: begin
        if (enable_p) begin
          acc_d   = {1'b0, a};
          m_reg_d = m;
          cnt_d   = m_size;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = w_reject ? S_IDLE : S_REDUCE;
      end
      S_REDUCE: begin
        // Add m when odd so the low bit clears, then divide by two.
        acc_d = acc_q[0] ? (w_sum >> 1) : (acc_q >> 1);
        cnt_d = cnt_q - 12'd1;
        if (cnt_q == 12'd1) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (w_ge) begin
          acc_d = w_sub;
        end else begin
          // Load y on entry to DONE so it is valid alongside done_irq_p.
          y_d     = acc_q[NBITS-1:0];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    done_irq_p = 1'b0;
    err_p      = 1'b0;
    case (state_q)
      S_CHECK: begin
        busy  = ~w_reject;
        err_p = w_reject;
      end
      S_REDUCE, S_FINAL: begin
        busy = 1'b1;
      end
      S_DONE: begin
        busy       = 1'b1;
        done_irq_p = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign y = y_q;

endmodule
`default_nettype wire
